// File: rtl/dram_cmd_scheduler.sv
// DDR4 command scheduler: turns one queued request at a time into PRE/ACT/RD/WR
// under an open-page policy, tracking per-bank open rows and tRCD/tRP/tRAS/CAS timing.
module dram_cmd_scheduler #(
  parameter int unsigned T_RCD = 24,
  parameter int unsigned T_RP  = 24,
  parameter int unsigned T_RAS = 52,
  parameter int unsigned T_CL  = 24,
  parameter int unsigned T_CWL = 20,
  parameter int unsigned T_BL  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [32:0] req_addr,
  output logic        cmd_valid,
  output logic [2:0]  cmd_type,
  output logic [1:0]  cmd_bg,
  output logic [1:0]  cmd_ba,
  output logic [14:0] cmd_row,
  output logic [9:0]  cmd_col,
  output logic        resp_valid,
  output logic [1:0]  resp_op
);

  localparam int unsigned RD_LAT = T_CL + T_BL;
  localparam int unsigned WR_LAT = T_CWL + T_BL;
  localparam int unsigned MAX_RC = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int unsigned MAX_DL = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int unsigned MAX_W  = (MAX_RC > MAX_DL) ? MAX_RC : MAX_DL;
  localparam int unsigned CNT_W  = $clog2(MAX_W + 1);
  localparam int unsigned TMR_W  = $clog2(T_RAS + 1);
  localparam int unsigned NBANK  = 16;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_PRE_HOLD, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_CAS, S_WAIT_DATA, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [1:0]  op_q;
  logic [3:0]  idx_q;
  logic [14:0] row_q;
  logic [9:0]  col_q;

  logic             bank_open [NBANK];
  logic [14:0]      bank_row  [NBANK];
  logic [TMR_W-1:0] ras_tmr   [NBANK];

  logic             accept;
  logic [1:0]       sel_op;
  logic [3:0]       sel_idx;
  logic [14:0]      sel_row;
  logic [9:0]       sel_col;
  logic             sel_open, sel_hit, ras_ok;
  logic [CNT_W-1:0] cas_wait;
  logic             unused_addr_bits;

  // Request fields come straight from the port on the accept edge, from the latch afterwards
  assign accept   = (state == S_IDLE) && req_valid && req_ready;
  assign sel_op   = accept ? req_op : op_q;
  assign sel_idx  = accept ? {req_addr[7:6], req_addr[9:8]} : idx_q;
  assign sel_row  = accept ? req_addr[32:18] : row_q;
  assign sel_col  = accept ? {req_addr[17:10], req_addr[5:4]} : col_q;
  assign sel_open = bank_open[sel_idx];
  assign sel_hit  = sel_open && (bank_row[sel_idx] == sel_row);
  assign ras_ok   = (ras_tmr[sel_idx] <= TMR_W'(1));
  assign cas_wait = (sel_op == 2'd1) ? CNT_W'(WR_LAT - 1) : CNT_W'(RD_LAT - 1);
  assign unused_addr_bits = ^req_addr[3:0];

  // Next-state: each command state lasts one cycle, waits count down to the next command
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (sel_hit)       state_nxt = S_CAS;
          else if (!sel_open) state_nxt = S_ACT;
          else if (ras_ok)   state_nxt = S_PRE;
          else               state_nxt = S_PRE_HOLD;
        end
      end
      S_PRE_HOLD: if (ras_ok) state_nxt = S_PRE;
      S_PRE: begin
        if (T_RP > 1) begin
          state_nxt = S_WAIT_RP;
          cnt_nxt   = CNT_W'(T_RP - 1);
        end else begin
          state_nxt = S_ACT;
        end
      end
      S_WAIT_RP: begin
        if (cnt <= CNT_W'(1)) state_nxt = S_ACT;
        else                  cnt_nxt   = cnt - CNT_W'(1);
      end
      S_ACT: begin
        if (T_RCD > 1) begin
          state_nxt = S_WAIT_RCD;
          cnt_nxt   = CNT_W'(T_RCD - 1);
        end else begin
          state_nxt = S_CAS;
        end
      end
      S_WAIT_RCD: begin
        if (cnt <= CNT_W'(1)) state_nxt = S_CAS;
        else                  cnt_nxt   = cnt - CNT_W'(1);
      end
      S_CAS: begin
        state_nxt = S_WAIT_DATA;
        cnt_nxt   = cas_wait;
      end
      S_WAIT_DATA: begin
        if (cnt <= CNT_W'(1)) state_nxt = S_DONE;
        else                  cnt_nxt   = cnt - CNT_W'(1);
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, latched request and outputs decoded from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      op_q       <= '0;
      idx_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      req_ready  <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_type   <= CMD_NOP;
      cmd_bg     <= '0;
      cmd_ba     <= '0;
      cmd_row    <= '0;
      cmd_col    <= '0;
      resp_valid <= 1'b0;
      resp_op    <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      req_ready  <= (state_nxt == S_IDLE);
      resp_valid <= (state_nxt == S_DONE);
      resp_op    <= (state_nxt == S_DONE) ? sel_op : 2'd0;
      cmd_valid  <= 1'b0;
      cmd_type   <= CMD_NOP;
      cmd_bg     <= '0;
      cmd_ba     <= '0;
      cmd_row    <= '0;
      cmd_col    <= '0;
      if (accept) begin
        op_q  <= req_op;
        idx_q <= sel_idx;
        row_q <= sel_row;
        col_q <= sel_col;
      end
      case (state_nxt)
        S_PRE: begin
          cmd_valid <= 1'b1;
          cmd_type  <= CMD_PRE;
          cmd_bg    <= sel_idx[3:2];
          cmd_ba    <= sel_idx[1:0];
        end
        S_ACT: begin
          cmd_valid <= 1'b1;
          cmd_type  <= CMD_ACT;
          cmd_bg    <= sel_idx[3:2];
          cmd_ba    <= sel_idx[1:0];
          cmd_row   <= sel_row;
        end
        S_CAS: begin
          cmd_valid <= 1'b1;
          cmd_type  <= (sel_op == 2'd1) ? CMD_WR : CMD_RD;
          cmd_bg    <= sel_idx[3:2];
          cmd_ba    <= sel_idx[1:0];
          cmd_col   <= sel_col;
        end
        default: ;
      endcase
    end
  end

  // Per-bank open-row table and tRAS timers; untouched banks keep their rows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NBANK; i++) begin
        bank_open[i] <= 1'b0;
        bank_row[i]  <= '0;
        ras_tmr[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NBANK; i++) begin
        if (ras_tmr[i] != '0) ras_tmr[i] <= ras_tmr[i] - TMR_W'(1);
        if (state_nxt == S_ACT && sel_idx == 4'(i)) begin
          bank_open[i] <= 1'b1;
          bank_row[i]  <= sel_row;
          ras_tmr[i]   <= TMR_W'(T_RAS);
        end else if (state_nxt == S_PRE && sel_idx == 4'(i)) begin
          bank_open[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Scoreboard bench for dram_cmd_scheduler: a bank/timing model pushes expected commands
// and completions per request; negedge monitors pop and compare them cycle-exactly.
`timescale 1ns/1ps
module tb_dram_cmd_scheduler;

  localparam int T_RCD = 24, T_RP = 24, T_RAS = 52, T_CL = 24, T_CWL = 20, T_BL = 4;
  localparam int T_RAS1 = 100;

  typedef struct packed {
    int          cyc;
    logic [2:0]  t;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [14:0] row;
    logic [9:0]  col;
  } cmd_t;

  typedef struct packed {
    int         cyc;
    logic [1:0] op;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic req_valid0, req_valid1;
  logic [1:0]  req_op;
  logic [32:0] req_addr;

  logic        req_ready0, cmd_valid0, resp_valid0;
  logic [2:0]  cmd_type0;
  logic [1:0]  cmd_bg0, cmd_ba0, resp_op0;
  logic [14:0] cmd_row0;
  logic [9:0]  cmd_col0;
  logic        req_ready1, cmd_valid1, resp_valid1;
  logic [2:0]  cmd_type1;
  logic [1:0]  cmd_bg1, cmd_ba1, resp_op1;
  logic [14:0] cmd_row1;
  logic [9:0]  cmd_col1;

  cmd_t  cq0[$], cq1[$];
  resp_t rq0[$], rq1[$];
  int checks = 0, errors = 0, cyc = 0;
  int a, r, rp;
  bit m_open [2][16];
  int m_row  [2][16];
  int m_act  [2][16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dram_cmd_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_op(req_op), .req_addr(req_addr), .cmd_valid(cmd_valid0), .cmd_type(cmd_type0),
    .cmd_bg(cmd_bg0), .cmd_ba(cmd_ba0), .cmd_row(cmd_row0), .cmd_col(cmd_col0),
    .resp_valid(resp_valid0), .resp_op(resp_op0)
  );

  dram_cmd_scheduler #(.T_RAS(T_RAS1)) dut_ras (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_op(req_op), .req_addr(req_addr), .cmd_valid(cmd_valid1), .cmd_type(cmd_type1),
    .cmd_bg(cmd_bg1), .cmd_ba(cmd_ba1), .cmd_row(cmd_row1), .cmd_col(cmd_col1),
    .resp_valid(resp_valid1), .resp_op(resp_op1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input int d, input int c, input logic [2:0] t, input int idx,
                          input int row, input int col);
    cmd_t e;
    e.cyc = c;
    e.t   = t;
    e.bg  = 2'(idx >> 2);
    e.ba  = 2'(idx);
    e.row = 15'(row);
    e.col = 10'(col);
    if (d == 0) cq0.push_back(e);
    else        cq1.push_back(e);
  endtask

  // Compare one DUT's outputs this cycle against the head of its expectation queues
  task automatic mon(input int d, input logic v, input logic [2:0] t, input logic [1:0] bg,
                     input logic [1:0] ba, input logic [14:0] row, input logic [9:0] col,
                     input logic rv, input logic [1:0] rop, input logic rdy);
    cmd_t  obs, e;
    resp_t robs, re;
    int    n;
    obs.cyc = cyc; obs.t = t; obs.bg = bg; obs.ba = ba; obs.row = row; obs.col = col;
    robs.cyc = cyc; robs.op = rop;
    if (v) begin
      n = (d == 0) ? cq0.size() : cq1.size();
      checks++;
      assert (n > 0) else begin
        errors++;
        $error("FAIL unexpected_cmd dut%0d: cyc=%0d type=%0d, none expected", d, cyc, t);
      end
      if (n > 0) begin
        if (d == 0) e = cq0.pop_front();
        else        e = cq1.pop_front();
        checks++;
        assert (obs === e) else begin
          errors++;
          $error("FAIL cmd dut%0d: observed cyc=%0d t=%0d bg=%0d ba=%0d row=%h col=%h, expected cyc=%0d t=%0d bg=%0d ba=%0d row=%h col=%h",
                 d, obs.cyc, obs.t, obs.bg, obs.ba, obs.row, obs.col, e.cyc, e.t, e.bg, e.ba, e.row, e.col);
        end
      end
    end else begin
      checks++;
      assert (t === 3'd0 && row === 15'd0 && col === 10'd0) else begin
        errors++;
        $error("FAIL nop_fields dut%0d: observed t=%0d row=%h col=%h, expected 0/0/0", d, t, row, col);
      end
    end
    if (rv) begin
      n = (d == 0) ? rq0.size() : rq1.size();
      checks++;
      assert (n > 0 && rdy === 1'b0) else begin
        errors++;
        $error("FAIL unexpected_resp dut%0d: cyc=%0d ready=%0b, expected none with ready=0", d, cyc, rdy);
      end
      if (n > 0) begin
        if (d == 0) re = rq0.pop_front();
        else        re = rq1.pop_front();
        checks++;
        assert (robs === re) else begin
          errors++;
          $error("FAIL resp dut%0d: observed cyc=%0d op=%0d, expected cyc=%0d op=%0d",
                 d, robs.cyc, robs.op, re.cyc, re.op);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, cmd_valid0, cmd_type0, cmd_bg0, cmd_ba0, cmd_row0, cmd_col0, resp_valid0, resp_op0, req_ready0);
      mon(1, cmd_valid1, cmd_type1, cmd_bg1, cmd_ba1, cmd_row1, cmd_col1, resp_valid1, resp_op1, req_ready1);
    end
  end

  // Drive a request until accepted, then push the model's expected command sequence
  task automatic issue(input int d, input logic [1:0] op, input logic [32:0] addr,
                       output int acc, output int rsp);
    int n, idx, row, col, pre, act, cas, ras;
    req_op   = op;
    req_addr = addr;
    if (d == 0) req_valid0 = 1'b1;
    else        req_valid1 = 1'b1;
    n = 0;
    while (((d == 0) ? req_ready0 : req_ready1) !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 300) else begin
      errors++;
      $error("FAIL accept_timeout dut%0d: waited %0d cycles, required < 300", d, n);
    end
    acc = cyc;
    idx = int'({addr[7:6], addr[9:8]});
    row = int'(addr[32:18]);
    col = int'({addr[17:10], addr[5:4]});
    ras = (d == 0) ? T_RAS : T_RAS1;
    if (m_open[d][idx] && m_row[d][idx] == row) begin
      cas = acc + 1;
    end else begin
      if (!m_open[d][idx]) begin
        act = acc + 1;
      end else begin
        pre = (acc + 1 > m_act[d][idx] + ras) ? acc + 1 : m_act[d][idx] + ras;
        push_cmd(d, pre, 3'd4, idx, 0, 0);
        act = pre + T_RP;
      end
      push_cmd(d, act, 3'd1, idx, row, 0);
      m_open[d][idx] = 1'b1;
      m_row[d][idx]  = row;
      m_act[d][idx]  = act;
      cas = act + T_RCD;
    end
    push_cmd(d, cas, (op == 2'd1) ? 3'd3 : 3'd2, idx, 0, col);
    rsp = cas + ((op == 2'd1) ? T_CWL : T_CL) + T_BL;
    if (d == 0) rq0.push_back('{rsp, op});
    else        rq1.push_back('{rsp, op});
    @(negedge clk);
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
    req_addr   = 33'({$urandom(), $urandom()});
    req_op     = 2'($urandom());
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((cq0.size() + cq1.size() + rq0.size() + rq1.size()) != 0 && n < 600) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    assert (n < 600) else begin
      errors++;
      $error("FAIL drain_timeout: %0d expectations left, expected 0", cq0.size() + cq1.size() + rq0.size() + rq1.size());
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) m_open[d][i] = 1'b0;
    cq0.delete(); cq1.delete(); rq0.delete(); rq1.delete();
  endtask

  initial begin
    rst_n = 1'b0; req_valid0 = 1'b0; req_valid1 = 1'b0; req_op = '0; req_addr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_outputs0", 64'({req_ready0, cmd_valid0, cmd_type0, cmd_bg0, cmd_ba0, cmd_row0, cmd_col0, resp_valid0, resp_op0}), 64'(0));
    chk("reset_outputs1", 64'({req_ready1, cmd_valid1, cmd_type1, cmd_bg1, cmd_ba1, cmd_row1, cmd_col1, resp_valid1, resp_op1}), 64'(0));
    rst_n = 1'b1;
    #1 chk("ready_at_release", 64'(req_ready0), 64'(0));
    @(negedge clk);
    chk("ready_after_release", 64'(req_ready0), 64'(1));

    // closed bank 0, then row hits on the same row with different columns
    issue(0, 2'd0, 33'h0, a, r);               wait_idle();
    rp = r; issue(0, 2'd0, 33'h400, a, r);     chk("accept_after_done_hit", 64'(a), 64'(rp + 1)); wait_idle();
    rp = r; issue(0, 2'd0, 33'h3FC30, a, r);   chk("accept_after_done_col", 64'(a), 64'(rp + 1)); wait_idle();
    // write to a different row of bank 0: precharge first
    rp = r; issue(0, 2'd1, 33'h1_0004_0000, a, r); chk("accept_after_done_wr", 64'(a), 64'(rp + 1)); wait_idle();
    // bank 5 opened, bank 0 conflict back to row 0, bank 5 still open afterwards
    issue(0, 2'd2, 33'h140, a, r);             wait_idle();
    issue(0, 2'd3, 33'h0, a, r);               wait_idle();
    issue(0, 2'd2, 33'h140, a, r);             wait_idle();

    // reset during the tRCD wait drops the request and forgets the open row
    issue(0, 2'd0, 33'h80300, a, r);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("mid_reset_outputs", 64'({req_ready0, cmd_valid0, cmd_type0, cmd_bg0, cmd_ba0, cmd_row0, cmd_col0, resp_valid0, resp_op0}), 64'(0));
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_mid_reset", 64'(req_ready0), 64'(1));
    issue(0, 2'd0, 33'h80300, a, r);           wait_idle();

    // long tRAS instance: conflicting row must wait for ACT + T_RAS before PRE
    issue(1, 2'd0, 33'h0, a, r);               wait_idle();
    rp = r; issue(1, 2'd0, 33'h40000, a, r);   chk("accept_after_done_ras", 64'(a), 64'(rp + 1)); wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
